aha_reset_requester: RTL and testbench

Initiator side of the platform four-phase reset REQ/ACK handshake. It converts single-cycle software reset triggers from the platform controller register file into compliant REQ sequences toward the per-peripheral reset generators. Covered peripherals include DMA, TLX, CGRA, NIC, timers, UARTs and WDOG. Each channel runs an independent FSM with ACK synchronisation, timeout supervision and sticky error status. The block sits in the platform controller in the SYS_FCLK domain.

---
 rtl/aha_reset_requester.sv | 139 +++++++++++++
 tb/tb_aha_reset_requester.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aha_reset_requester.sv
// Initiator side of the four-phase reset REQ/ACK handshake.
// One independent channel FSM per peripheral, with an ACK synchroniser, a timeout and a sticky error flag.
module aha_reset_requester_ch #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    input  logic err_clr,
    output logic req,
    output logic busy,
    output logic done,
    output logic err,
    output logic err_nxt
);
    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [1:0]       ack_pipe;
    logic [CNT_W-1:0] cnt;
    logic             ack_s;
    logic             timeout_hit;
    logic             err_set;

    assign ack_s       = ack_pipe[1];
    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    // Stale ACK on a request, or a phase that ran out of time, raises the error.
    always_comb begin
        err_set = 1'b0;
        case (state)
            IDLE:    err_set = start && ack_s;
            REQ_HI:  err_set = !ack_s && timeout_hit;
            REQ_LO:  err_set = ack_s && timeout_hit;
            default: err_set = 1'b0;
        endcase
    end

    // Set wins over clear in the same cycle.
    assign err_nxt = err_set | (err & ~err_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ack_pipe <= '0;
            cnt      <= '0;
            req      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack_pipe <= {ack_pipe[0], ack};
            err      <= err_nxt;
            done     <= 1'b0;
            if (cnt != '1)
                cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start && !ack_s) begin
                        state <= REQ_HI;
                        req   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                REQ_HI: begin
                    if (ack_s || timeout_hit) begin
                        state <= REQ_LO;
                        req   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                REQ_LO: begin
                    if (!ack_s || timeout_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

module aha_reset_requester #(
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] START,
    output logic [NUM_CH-1:0] REQ,
    input  logic [NUM_CH-1:0] ACK,
    output logic [NUM_CH-1:0] BUSY,
    output logic [NUM_CH-1:0] DONE,
    output logic [NUM_CH-1:0] ERR,
    input  logic [NUM_CH-1:0] ERR_CLR,
    output logic              IRQ
);
    logic [NUM_CH-1:0] err_nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        aha_reset_requester_ch #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk     (CLK),
            .reset   (RESET),
            .start   (START[g]),
            .ack     (ACK[g]),
            .err_clr (ERR_CLR[g]),
            .req     (REQ[g]),
            .busy    (BUSY[g]),
            .done    (DONE[g]),
            .err     (ERR[g]),
            .err_nxt (err_nxt[g])
        );
    end

    // Registered from next-state ERR so IRQ lines up with ERR.
    always_ff @(posedge CLK) begin
        if (RESET)
            IRQ <= 1'b0;
        else
            IRQ <= |err_nxt;
    end
endmodule

// File: tb/tb_aha_reset_requester.sv
// Randomised scoreboard bench: two DUTs (timeout 8 and timeout disabled) against a phase/elapsed-time model.
module tb_aha_reset_requester;
    localparam int NUM_CH = 4;
    localparam int MAXC   = 8000;
    localparam int TMO [2] = '{8, 0};

    typedef struct packed {
        logic [NUM_CH-1:0] req;
        logic [NUM_CH-1:0] busy;
        logic [NUM_CH-1:0] done;
        logic [NUM_CH-1:0] err;
        logic              irq;
    } obs_t;

    typedef struct packed {
        int   cyc;
        obs_t o0;
        obs_t o1;
    } exp_t;

    logic              CLK;
    logic              RESET;
    logic [NUM_CH-1:0] START, ERR_CLR;
    logic [NUM_CH-1:0] ACK0, ACK1;
    logic [NUM_CH-1:0] REQ0, BUSY0, DONE0, ERR0;
    logic [NUM_CH-1:0] REQ1, BUSY1, DONE1, ERR1;
    logic              IRQ0, IRQ1;

    aha_reset_requester #(.NUM_CH(NUM_CH), .TIMEOUT_CYCLES(8), .CNT_W(8)) u_dut (
        .CLK(CLK), .RESET(RESET), .START(START), .REQ(REQ0), .ACK(ACK0),
        .BUSY(BUSY0), .DONE(DONE0), .ERR(ERR0), .ERR_CLR(ERR_CLR), .IRQ(IRQ0));

    aha_reset_requester #(.NUM_CH(NUM_CH), .TIMEOUT_CYCLES(0), .CNT_W(8)) u_dut_noto (
        .CLK(CLK), .RESET(RESET), .START(START), .REQ(REQ1), .ACK(ACK1),
        .BUSY(BUSY1), .DONE(DONE1), .ERR(ERR1), .ERR_CLR(ERR_CLR), .IRQ(IRQ1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   cyc;
    int   n_chk, n_pass;
    exp_t q[$];

    // Reference model: phase 0 idle, 1 request high, 2 request low; elapsed time = cyc - ph_start.
    int                ph       [2][NUM_CH];
    int                ph_start [2][NUM_CH];
    logic              err_m    [2][NUM_CH];
    int                last_rst;
    logic [NUM_CH-1:0] ack_log  [2][0:MAXC];
    logic [NUM_CH-1:0] req_log  [2][0:MAXC];

    // Responder: 0 follows expected REQ after dly cycles, 1 stuck high, 2 stuck low.
    int mode [2][NUM_CH];
    int dly  [2][NUM_CH];

    task automatic chk(input int d, input obs_t got, input obs_t exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL dut%0d cyc %0d: got req=%b busy=%b done=%b err=%b irq=%b, expected req=%b busy=%b done=%b err=%b irq=%b",
                     d, cyc, got.req, got.busy, got.done, got.err, got.irq,
                     exp.req, exp.busy, exp.done, exp.err, exp.irq);
    endtask

    function automatic logic ack_sync(input int d, input int ch, input int c);
        if (c - 2 > last_rst && c >= 2)
            return ack_log[d][c-2][ch];
        return 1'b0;
    endfunction

    task automatic step(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] clr, input logic rst);
        logic [NUM_CH-1:0] av [2];
        obs_t              o  [2];
        exp_t              e;
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                case (mode[d][ch])
                    1:       av[d][ch] = 1'b1;
                    2:       av[d][ch] = 1'b0;
                    default: av[d][ch] = (cyc >= dly[d][ch]) ? req_log[d][cyc - dly[d][ch]][ch] : 1'b0;
                endcase
            end
            ack_log[d][cyc] = av[d];
        end
        RESET   = rst;
        START   = st;
        ERR_CLR = clr;
        ACK0    = av[0];
        ACK1    = av[1];

        for (int d = 0; d < 2; d++) begin
            o[d] = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                logic as, to, set, dn;
                int   el;
                set = 1'b0;
                dn  = 1'b0;
                if (rst) begin
                    ph[d][ch]    = 0;
                    err_m[d][ch] = 1'b0;
                end else begin
                    as = ack_sync(d, ch, cyc);
                    el = cyc - ph_start[d][ch];
                    to = (TMO[d] != 0) && (el == TMO[d] - 1);
                    case (ph[d][ch])
                        0: if (st[ch]) begin
                            if (as) set = 1'b1;
                            else begin ph[d][ch] = 1; ph_start[d][ch] = cyc + 1; end
                        end
                        1: if (as || to) begin
                            set = !as; ph[d][ch] = 2; ph_start[d][ch] = cyc + 1;
                        end
                        default: if (!as || to) begin
                            set = as; ph[d][ch] = 0; dn = 1'b1;
                        end
                    endcase
                    err_m[d][ch] = set | (err_m[d][ch] & ~clr[ch]);
                end
                o[d].req[ch]  = (ph[d][ch] == 1);
                o[d].busy[ch] = (ph[d][ch] != 0);
                o[d].done[ch] = dn;
                o[d].err[ch]  = err_m[d][ch];
            end
            o[d].irq = |o[d].err;
            req_log[d][cyc+1] = o[d].req;
        end
        if (rst) last_rst = cyc;
        e.cyc = cyc + 1;
        e.o0  = o[0];
        e.o1  = o[1];
        q.push_back(e);
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step('0, '0, 1'b0);
    endtask

    task automatic set_mode(input int ch, input int m, input int dl);
        for (int d = 0; d < 2; d++) begin
            mode[d][ch] = m;
            dly[d][ch]  = dl;
        end
    endtask

    // Monitor: compares the DUT against the expected entry tagged for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk(0, {REQ0, BUSY0, DONE0, ERR0, IRQ0}, e.o0);
                chk(1, {REQ1, BUSY1, DONE1, ERR1, IRQ1}, e.o1);
            end
        end
    end

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        cyc      = 0;
        last_rst = 0;
        RESET    = 1'b1;
        START    = '0;
        ERR_CLR  = '0;
        ACK0     = '0;
        ACK1     = '0;
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                ph[d][ch] = 0; ph_start[d][ch] = 0; err_m[d][ch] = 1'b0;
                mode[d][ch] = 0; dly[d][ch] = 3;
            end
            req_log[d][0] = '0;
        end
        @(posedge CLK);
        #1;

        repeat (3) step('0, '0, 1'b1);

        // Normal handshake on ch0 with START spam, parallel START on ch3
        step(4'b1001, '0, 1'b0);
        repeat (15) step(4'b0001, '0, 1'b0);
        run(20);

        // Request-phase timeout on ch1 with a dead responder
        set_mode(1, 2, 3);
        step(4'b0010, '0, 1'b0);
        run(25);
        set_mode(1, 0, 3);
        run(20);

        // Stale ACK on ch2, then clear the error
        set_mode(2, 1, 3);
        run(4);
        step(4'b0100, '0, 1'b0);
        run(4);
        step('0, 4'b0100, 1'b0);
        run(4);
        set_mode(2, 0, 3);
        run(6);

        // Reset while ch0 is in the request phase, then a fresh sequence
        step(4'b0001, '0, 1'b0);
        run(3);
        step('0, '0, 1'b1);
        run(2);
        step(4'b0001, '0, 1'b0);
        run(20);

        // Long silent responder: timed-out DUT recovers, timeout-disabled DUT holds REQ
        set_mode(0, 2, 2);
        step(4'b0001, '0, 1'b0);
        run(1000);
        set_mode(0, 0, 2);
        run(30);

        // Randomised traffic
        repeat (3000) begin
            if (cyc % 64 == 0) begin
                for (int d = 0; d < 2; d++)
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        int r;
                        r = $urandom_range(0, 9);
                        mode[d][ch] = (r < 6) ? 0 : (r < 8) ? 1 : 2;
                        dly[d][ch]  = $urandom_range(0, 11);
                    end
            end
            begin
                logic [NUM_CH-1:0] st, clr;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    st[ch]  = ($urandom_range(0, 5) == 0);
                    clr[ch] = ($urandom_range(0, 11) == 0);
                end
                step(st, clr, ($urandom_range(0, 399) == 0));
            end
        end
        run(20);
        @(negedge CLK);
        @(negedge CLK);

        n_chk++;
        if (q.size() == 0)
            n_pass++;
        else
            $display("FAIL scoreboard drain: got %0d pending entries, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
